// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM encoding and
// channel/select widths of the downstream 4:1 mux.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational picker for the next enabled channel. With first_i set it returns
// the lowest enabled channel; otherwise it returns the lowest enabled channel above cur_i.
module mux_scan_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              first_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              found_o
);

  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    // Walk from the top so the lowest qualifying channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (SEL_W'(i) > cur_i))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller driving a 4:1 mux select: steps through enabled channels,
// waits dwell+1 cycles on each, samples mux_out, and hands off a 4-bit word.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               sample_valid,
  output logic [NUM_CH-1:0]  sample_data,
  input  logic               sample_ready,
  output logic               done,
  output state_e             dbg_state
);

  // Handshake: sample_data is offered while sample_valid is high and is held
  // stable until a cycle with sample_ready high; that cycle is the transfer,
  // and done pulses in the following cycle.

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [NUM_CH-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;

  logic                nc_first;
  logic [NUM_CH-1:0]   nc_mask;
  logic [SEL_W-1:0]    nc_idx;
  logic                nc_found;

  // In IDLE the picker sees the live mask for the initial choice; afterwards the latched one.
  assign nc_first = (state_q == ST_IDLE);
  assign nc_mask  = nc_first ? chan_mask : mask_q;

  mux_scan_next_ch u_next_ch (
    .mask_i  (nc_mask),
    .cur_i   (sel_q),
    .first_i (nc_first),
    .nxt_o   (nc_idx),
    .found_o (nc_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mask_d  = chan_mask;
          dwell_d = dwell;
          cnt_d   = dwell;
          data_d  = '0;
          if (nc_found) begin
            sel_d   = nc_idx;
            state_d = ST_SETTLE;
          end else begin
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d[sel_q] = mux_out;
          if (nc_found) begin
            sel_d = nc_idx;
            cnt_d = dwell_q;
          end else begin
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          sel_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything but leaves the partial word visible.
    if (abort) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: models the 4:1 mux, walks the expected
// select sequence and compares each completed word against a scoreboard queue.
module tb_mux_scan_ctrl;
  import mux_scan_ctrl_pkg::*;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] dwell;
  logic [3:0]    chan_mask;
  logic [3:0]    mux_in;
  logic          mux_out;
  logic [1:0]    sel;
  logic          busy;
  logic          sample_valid;
  logic [3:0]    sample_data;
  logic          sample_ready;
  logic          done;
  state_e        dbg_state;

  logic [3:0] exp_q[$];
  int chk_cnt = 0;
  int err_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign mux_out = mux_in[sel];

  mux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .dwell        (dwell),
    .chan_mask    (chan_mask),
    .mux_out      (mux_out),
    .sel          (sel),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"},   32'(sel), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // driver: one complete scan from start pulse to handshake (or abort in HOLD)
  task automatic run_scan(input logic [3:0] m, input logic [DW-1:0] dw, input logic [3:0] mi,
                          input int rdy_wait, input bit start_in_hold, input bit abort_in_hold);
    logic [1:0] last_ch;
    logic [3:0] exp_d;
    last_ch   = 2'd0;
    mux_in    = mi;
    chan_mask = m;
    dwell     = dw;
    start     = 1'b1;
    exp_q.push_back(m & mi);
    @(negedge clk);
    start     = 1'b0;
    chan_mask = 4'($urandom_range(0, 15));
    dwell     = DW'($urandom_range(0, 15));
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        last_ch = 2'(ch);
        for (int c = 0; c <= int'(dw); c++) begin
          check("sel_step", 32'(sel), 32'(ch));
          check("busy_scan", 32'(busy), 32'd1);
          check("valid_early", 32'(sample_valid), 32'd0);
          check("done_quiet", 32'(done), 32'd0);
          @(negedge clk);
        end
      end
    end
    check("valid_rise", 32'(sample_valid), 32'd1);
    check("busy_hold", 32'(busy), 32'd1);
    exp_d = exp_q.pop_front();
    check("data", 32'(sample_data), 32'(exp_d));
    for (int c = 0; c < rdy_wait; c++) begin
      start = start_in_hold && (c == 1);
      @(negedge clk);
      check("hold_valid", 32'(sample_valid), 32'd1);
      check("hold_data", 32'(sample_data), 32'(exp_d));
      check("hold_sel", 32'(sel), 32'(last_ch));
      check("hold_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    if (abort_in_hold) begin
      abort        = 1'b1;
      sample_ready = 1'b1;
      @(negedge clk);
      abort        = 1'b0;
      sample_ready = 1'b0;
      check("abort_rdy_done", 32'(done), 32'd0);
      check("abort_rdy_data", 32'(sample_data), 32'(exp_d));
      check_idle("abort_rdy");
    end else begin
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
      check("hs_done", 32'(done), 32'd1);
      check_idle("hs");
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    dwell        = '0;
    chan_mask    = '0;
    mux_in       = '0;
    sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_data", 32'(sample_data), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // full mask, no dwell: a=1 b=0 c=1 d=0
    run_scan(4'b1111, 4'd0, 4'b0101, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // sparse mask with dwell
    run_scan(4'b1010, 4'd2, 4'b1111, 0, 1'b0, 1'b0);
    @(negedge clk);

    // empty mask
    run_scan(4'b0000, 4'd5, 4'b1111, 2, 1'b0, 1'b0);
    @(negedge clk);

    // backpressure with ignored start, then back-to-back scan from the done cycle
    run_scan(4'b1101, 4'd1, 4'b0110, 5, 1'b1, 1'b0);
    run_scan(4'b0110, 4'd1, 4'b1111, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_done_drop", 32'(done), 32'd0);

    // abort during channel 2
    mux_in    = 4'b1011;
    chan_mask = 4'b1111;
    dwell     = 4'd3;
    start     = 1'b1;
    exp_q.push_back(4'b0011);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_pre_sel", 32'(sel), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    check("abort_done", 32'(done), 32'd0);
    check("abort_partial", 32'(sample_data), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);

    // asynchronous reset mid-scan
    mux_in    = 4'b1111;
    chan_mask = 4'b1111;
    dwell     = 4'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_data", 32'(sample_data), 32'd1);
    check("pre_rst_sel", 32'(sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_data", 32'(sample_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // abort and ready together in HOLD
    run_scan(4'b1111, 4'd1, 4'b1001, 2, 1'b0, 1'b1);
    @(negedge clk);
    check("abort_rdy_no_done", 32'(done), 32'd0);

    // random scans
    repeat (6) begin
      run_scan(4'($urandom_range(0, 15)), DW'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1, 1'b0);
      @(negedge clk);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
